// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder and hard-decision Viterbi decoder
// with register-exchange survivors; both halves share one clock and reset.
module viterbi_codec #(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_enable_i,
  input  logic       enc_d_i,
  output logic       enc_valid_o,
  output logic [1:0] enc_d_o,
  input  logic       dec_enable_i,
  input  logic [1:0] dec_d_i,
  output logic       dec_valid_o,
  output logic       dec_d_o
);

  localparam int unsigned CNT_W  = $clog2(TB_DEPTH + 1);
  localparam int unsigned SUM_W  = PM_W + 2;
  localparam int unsigned NSTATE = 4;
  localparam logic [PM_W-1:0]  PM_MAX  = '1;
  localparam logic [PM_W-1:0]  PM_INIT = PM_W'(4);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(TB_DEPTH - 1);

  // ---------------- encoder ----------------
  logic enc_a;
  logic enc_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_a       <= 1'b0;
      enc_b       <= 1'b0;
      enc_d_o     <= 2'b00;
      enc_valid_o <= 1'b0;
    end else if (enc_enable_i) begin
      enc_d_o     <= {enc_d_i ^ enc_a ^ enc_b, enc_d_i ^ enc_b};
      enc_a       <= enc_d_i;
      enc_b       <= enc_a;
      enc_valid_o <= 1'b1;
    end else begin
      enc_valid_o <= 1'b0;
    end
  end

  // ---------------- decoder state ----------------
  logic [PM_W-1:0]     pm   [NSTATE];
  logic [TB_DEPTH-1:0] surv [NSTATE];
  logic [CNT_W-1:0]    cnt;

  logic [1:0]          bm0      [NSTATE];
  logic [1:0]          bm1      [NSTATE];
  logic [SUM_W-1:0]    cand0    [NSTATE];
  logic [SUM_W-1:0]    cand1    [NSTATE];
  logic [SUM_W-1:0]    acc      [NSTATE];
  logic [SUM_W-1:0]    norm     [NSTATE];
  logic [PM_W-1:0]     pm_new   [NSTATE];
  logic [TB_DEPTH-1:0] surv_new [NSTATE];
  logic [1:0]          exp0     [NSTATE];
  logic [1:0]          exp1     [NSTATE];
  logic [1:0]          pred0    [NSTATE];
  logic [1:0]          pred1    [NSTATE];
  logic [NSTATE-1:0]   sel1;
  logic [SUM_W-1:0]    acc_min;
  logic [1:0]          best;

  // Add-compare-select: new state {d,a} is reached from {a,0} or {a,1}
  always_comb begin
    acc_min = '1;
    for (int i = 0; i < NSTATE; i++) begin
      pred0[i]    = {i[0], 1'b0};
      pred1[i]    = {i[0], 1'b1};
      exp0[i]     = {i[1] ^ i[0], i[1]};
      exp1[i]     = {~(i[1] ^ i[0]), ~i[1]};
      bm0[i]      = 2'((dec_d_i[1] ^ exp0[i][1])) + 2'((dec_d_i[0] ^ exp0[i][0]));
      bm1[i]      = 2'((dec_d_i[1] ^ exp1[i][1])) + 2'((dec_d_i[0] ^ exp1[i][0]));
      cand0[i]    = SUM_W'(pm[pred0[i]]) + SUM_W'(bm0[i]);
      cand1[i]    = SUM_W'(pm[pred1[i]]) + SUM_W'(bm1[i]);
      // Ties resolve to the b=0 predecessor
      sel1[i]     = (cand1[i] < cand0[i]);
      acc[i]      = sel1[i] ? cand1[i] : cand0[i];
      surv_new[i] = sel1[i] ? {surv[pred1[i]][TB_DEPTH-2:0], i[1]}
                            : {surv[pred0[i]][TB_DEPTH-2:0], i[1]};
      if (acc[i] < acc_min) acc_min = acc[i];
    end
  end

  // Normalise so the best metric is 0, saturate, and pick the best state
  always_comb begin
    best = 2'd0;
    for (int i = 0; i < NSTATE; i++) begin
      norm[i]   = acc[i] - acc_min;
      pm_new[i] = (norm[i] > SUM_W'(PM_MAX)) ? PM_MAX : PM_W'(norm[i]);
    end
    for (int i = 1; i < NSTATE; i++) begin
      if (pm_new[i] < pm_new[best]) best = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTATE; i++) begin
        pm[i]   <= (i == 0) ? '0 : PM_INIT;
        surv[i] <= '0;
      end
      cnt         <= '0;
      dec_d_o     <= 1'b0;
      dec_valid_o <= 1'b0;
    end else if (dec_enable_i) begin
      for (int i = 0; i < NSTATE; i++) begin
        pm[i]   <= pm_new[i];
        surv[i] <= surv_new[i];
      end
      if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      dec_d_o     <= surv_new[best][TB_DEPTH-1];
      dec_valid_o <= (cnt >= CNT_THR);
    end else begin
      dec_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_viterbi_codec.sv
// Directed bench for viterbi_codec: encoder model, loopback through a one-cycle
// register, and a queue of sent bits compared against decoded output.
module tb_viterbi_codec;

  localparam int unsigned TB_DEPTH = 16;
  localparam int unsigned PM_W     = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_enable_i = 1'b0;
  logic       enc_d_i = 1'b0;
  logic       enc_valid_o;
  logic [1:0] enc_d_o;
  logic       dec_enable_i = 1'b0;
  logic [1:0] dec_d_i = 2'b00;
  logic       dec_valid_o;
  logic       dec_d_o;

  always #5 clk = ~clk;

  viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_valid_o  (dec_valid_o),
    .dec_d_o      (dec_d_o)
  );

  int         n_vec = 0;
  int         n_err = 0;
  bit         sent_q[$];
  int         dec_cnt = 0;
  logic       exp_dec_valid = 1'b0;
  logic       exp_enc_valid = 1'b0;
  logic [1:0] exp_enc_sym = 2'b00;
  logic       ea = 1'b0;
  logic       eb = 1'b0;
  bit         ref_bits[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check last edge, loop the encoder output into the decoder, drive encoder
  task automatic cycle(input logic en, input logic d, input logic flip);
    bit b;
    @(negedge clk);
    chk("enc_valid", 32'(enc_valid_o), 32'(exp_enc_valid));
    chk("enc_sym", 32'(enc_d_o), 32'(exp_enc_sym));
    chk("dec_valid", 32'(dec_valid_o), 32'(exp_dec_valid));
    if (exp_dec_valid) begin
      if (sent_q.size() == 0) begin
        chk("dec_queue_empty", 32'(sent_q.size()), 32'd1);
      end else begin
        b = sent_q.pop_front();
        chk("dec_bit", 32'(dec_d_o), 32'(b));
      end
    end
    dec_enable_i  = enc_valid_o;
    dec_d_i       = enc_d_o ^ {1'b0, flip};
    exp_dec_valid = enc_valid_o && (dec_cnt >= int'(TB_DEPTH) - 1);
    if (enc_valid_o && dec_cnt < int'(TB_DEPTH)) dec_cnt++;
    enc_enable_i  = en;
    enc_d_i       = d;
    exp_enc_valid = en;
    if (en) begin
      sent_q.push_back(d);
      exp_enc_sym = {d ^ ea ^ eb, d ^ eb};
      eb = ea;
      ea = d;
    end
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    chk("tail_left", 32'(sent_q.size()), 32'(TB_DEPTH - 1));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any edge
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    enc_enable_i = 1'b0;
    enc_d_i = 1'b0;
    dec_enable_i = 1'b0;
    dec_d_i = 2'b00;
    #1;
    chk("rst_enc_valid", 32'(enc_valid_o), 32'd0);
    chk("rst_enc_sym", 32'(enc_d_o), 32'd0);
    chk("rst_dec_valid", 32'(dec_valid_o), 32'd0);
    chk("rst_dec_bit", 32'(dec_d_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sent_q.delete();
    dec_cnt = 0;
    ea = 1'b0;
    eb = 1'b0;
    exp_enc_sym = 2'b00;
    exp_enc_valid = 1'b0;
    exp_dec_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] imp[4];
    int idx;
    int guard;
    int pos;
    imp[0] = 2'b11; imp[1] = 2'b10; imp[2] = 2'b11; imp[3] = 2'b00;

    do_reset();

    // Encoder impulse response
    for (int k = 0; k < 4; k++) begin
      enc_enable_i = 1'b1;
      enc_d_i = (k == 0);
      @(negedge clk);
      chk("impulse_sym", 32'(enc_d_o), 32'(imp[k]));
      chk("impulse_valid", 32'(enc_valid_o), 32'd1);
    end
    enc_enable_i = 1'b0;
    @(negedge clk);
    chk("impulse_idle_valid", 32'(enc_valid_o), 32'd0);
    chk("impulse_hold_sym", 32'(enc_d_o), 32'd0);

    // All-zero loopback
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b0, 1'b0);
    drain();

    // Clean random loopback
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ref_bits[i] = 1'($urandom_range(0, 1));
      cycle(1'b1, ref_bits[i], 1'b0);
    end
    drain();

    // One flipped g1 bit per 8-symbol window
    do_reset();
    pos = 0;
    for (int i = 0; i < 256; i++) begin
      if (i % 8 == 0) pos = $urandom_range(0, 7);
      cycle(1'b1, 1'($urandom_range(0, 1)), (i % 8) == pos);
    end
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    drain();

    // Same bits as the clean run with ~30% idle cycles
    do_reset();
    idx = 0;
    guard = 0;
    while (idx < 256 && guard < 2000) begin
      guard++;
      if ($urandom_range(0, 9) >= 3) begin
        cycle(1'b1, ref_bits[idx], 1'b0);
        idx++;
      end else begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    chk("gap_run_complete", 32'(idx), 32'd256);
    drain();

    // Reset in the middle of a stream, then a fresh loopback
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/viterbi_codec.md
# viterbi_codec

Rate-1/2, constraint-length-3 convolutional encoder plus a matching hard-decision Viterbi decoder in one block. The encoder side feeds a (possibly corrupting) channel. The decoder side recovers the original bit stream from the received symbol pairs. It is the transmit/receive core of the channel-coding datapath, and both halves share one clock and one reset.

## Interface
- `TB_DEPTH`, default 16: survivor (traceback) depth in symbols, ≥ 4.
- `PM_W`, default 5: path-metric width in bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high; one clock, no other clock domains.
- `enc_enable_i`  in  1  encoder input bit valid this cycle.
- `enc_d_i`  in  1  encoder data bit.
- `enc_valid_o`  out  1  `enc_d_o` holds a fresh symbol.
- `enc_d_o`  out  2  encoded symbol `{g0, g1}`.
- `dec_enable_i`  in  1  decoder symbol valid this cycle.
- `dec_d_i`  in  2  received symbol `{g0, g1}`, hard bits.
- `dec_valid_o`  out  1  `dec_d_o` holds a meaningful decoded bit.
- `dec_d_o`  out  1  decoded bit.

## Operation
Encoder:
- State register `{a, b}`: `a` = previous input bit, `b` = the bit before it.
- Generators are g0 = 111 and g1 = 101 (octal 7, 5).
- On an edge with `enc_enable_i = 1`:
  - `enc_d_o[1] <= d ^ a ^ b`
  - `enc_d_o[0] <= d ^ b`
  - `{a, b} <= {d, a}`
  - `enc_valid_o <= 1`
- With `enc_enable_i = 0`: state and `enc_d_o` hold, and `enc_valid_o <= 0`.

Decoder:
- Trellis:
  - 4 states S = `{a, b}`, encoded 0..3 as `2a + b`.
  - Input `d` moves state `{a, b}` to `{d, a}` and emits `{d^a^b, d^b}`.
  - Predecessors of `{d, a}` are `{a, 0}` and `{a, 1}`.
- Branch metric: Hamming distance between `dec_d_i` and the expected symbol, range 0..2.
- ACS, on an edge with `dec_enable_i = 1`:
  - For each new state, the candidate metric is `PM[pred] + BM`; keep the smaller.
  - Tie: choose the predecessor with `b = 0`.
  - Subtract the minimum of the four new metrics from all four, so the best metric is always 0.
  - Saturate at 2^PM_W − 1.
- Survivors: register-exchange.
  - Each state holds a `TB_DEPTH`-bit path.
  - New path = `{surv[pred][TB_DEPTH-2:0], d}`.
- Output:
  - `best` = new state with the minimum metric; ties go to the lowest index.
  - `dec_d_o <= surv_new[best][TB_DEPTH-1]`.
- Valid counter: counts enabled symbols since reset, saturating at `TB_DEPTH`. `dec_valid_o <= dec_enable_i && (count_before_increment >= TB_DEPTH-1)`.
- With `dec_enable_i = 0`: metrics, survivors, counter and `dec_d_o` hold, and `dec_valid_o <= 0`.
- Error-correcting requirement: an isolated single-bit error per 8 symbols must produce zero output errors (free distance 5).

## Timing
Reset values:
- Encoder: `{a, b} = 0`, `enc_d_o = 00`, `enc_valid_o = 0`.
- Decoder:
  - PM[0] = 0, PM[1..3] = 4; the trellis starts in state 0.
  - All survivors 0, counter 0, `dec_d_o = 0`, `dec_valid_o = 0`.

Latency and ordering:
- Encoder latency is 1 clock: a bit accepted at edge k appears on `enc_d_o` after edge k.
- Decoder latency: the bit for the j-th enabled symbol (j from 0) is on `dec_d_o` after the edge that accepts symbol j + TB_DEPTH − 1. This is the first edge where `dec_valid_o` is 1.
- Enable gaps on either side stall state without corruption. Latency is counted in enabled symbols, not clocks.
- Reset asserted mid-stream: all registers return to reset values immediately, without waiting for a clock edge. Decoding restarts from state 0 and the valid counter restarts.
- Encoder and decoder are independent. The system wiring adds one register stage, with `dec_enable_i` = delayed `enc_valid_o`, and the decoder requires no other alignment.

## Test plan
- Encoder impulse: bits 1,0,0,0 with enable high → `enc_d_o` = 11, 10, 11, 00, and `enc_valid_o` = 1 from the first edge after enable.
- All-zero loopback (encoder → 1-cycle register → decoder), 64 bits → `dec_d_o` = 0 throughout; `dec_valid_o` rises after the 16th enabled symbol; metrics stay 0 for state 0.
- Clean loopback of 256 random bits → output equals input delayed by TB_DEPTH − 1 symbols, zero mismatches.
- Flip `dec_d_i[0]` once in every 8-symbol window (random position in the window), 256 symbols → zero decoded-bit errors.
- Random enable gaps (about 30% idle) on the encoder, propagated to the decoder → same decoded sequence as the gap-free run; `dec_valid_o` low on idle cycles.
- Assert `rst` mid-stream for one cycle → all outputs and `dec_valid_o` go to 0 at once; after release a fresh 64-bit loopback decodes correctly with full latency.
